// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues sequential word fetches, tags in-order
// responses with their request PC, buffers them for decode, and flushes
// on redirect while discarding responses to stale in-flight requests.
// Optional build macro FETCH_QUEUE_BYPASS_EN: a response arriving into an
// empty queue is presented to decode in the same cycle.
module instr_fetch_queue #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic                      imem_req_valid,
    output logic [ADDR_WIDTH-1:0]     imem_req_addr,
    input  logic                      imem_req_ready,
    input  logic                      imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]     imem_rsp_data,
    output logic                      dec_valid,
    output logic [DATA_WIDTH-1:0]     dec_instr,
    output logic [ADDR_WIDTH-1:0]     dec_pc,
    input  logic                      dec_ready,
    input  logic                      redirect_valid,
    input  logic [ADDR_WIDTH-1:0]     redirect_pc,
    output logic [$clog2(DEPTH):0]    occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } entry_t;

    // decoded-instruction queue
    entry_t                q_mem [DEPTH];
    logic [PW-1:0]         q_rd, q_wr;
    logic [CW-1:0]         q_cnt;

    // PCs of in-flight requests, consumed in response order
    logic [ADDR_WIDTH-1:0] pcq [DEPTH];
    logic [PW-1:0]         pcq_rd, pcq_wr;

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [CW-1:0]         out_cnt;   // all in-flight requests, stale included
    logic [CW-1:0]         disc_cnt;  // stale subset of out_cnt

    logic [CW:0]           inflight;
    logic                  accept, rsp_fire, rsp_keep, byp, push, pop, head_valid;
    logic [CW-1:0]         out_nxt;

    // Credit check is purely on registered counts; reset forces it low.
    assign inflight       = {1'b0, q_cnt} + {1'b0, out_cnt};
    assign imem_req_valid = rst_n & (inflight < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign accept         = imem_req_valid & imem_req_ready;

    // A response with nothing outstanding is illegal and ignored entirely.
    assign rsp_fire   = imem_rsp_valid & (out_cnt != '0);
    assign rsp_keep   = rsp_fire & (disc_cnt == '0) & ~redirect_valid;
    assign head_valid = (q_cnt != '0);

`ifdef FETCH_QUEUE_BYPASS_EN
    assign byp = rsp_keep & ~head_valid;
`else
    assign byp = 1'b0;
`endif

    assign push    = rsp_keep & ~(byp & dec_ready);
    assign pop     = head_valid & dec_ready & ~redirect_valid;
    assign out_nxt = out_cnt + CW'(accept) - CW'(rsp_fire);

    // Head (or bypassed response) toward decode; zero when nothing valid.
    always_comb begin
        dec_valid = head_valid | byp;
        dec_instr = '0;
        dec_pc    = '0;
        if (head_valid) begin
            dec_instr = q_mem[q_rd].instr;
            dec_pc    = q_mem[q_rd].pc;
        end else if (byp) begin
            dec_instr = imem_rsp_data;
            dec_pc    = pcq[pcq_rd];
        end
    end

    assign occupancy = q_cnt;

    // Control state: fetch PC, counters and pointers; redirect wins over push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            out_cnt  <= '0;
            disc_cnt <= '0;
            q_cnt    <= '0;
            q_rd     <= '0;
            q_wr     <= '0;
            pcq_rd   <= '0;
            pcq_wr   <= '0;
        end else begin
            out_cnt <= out_nxt;
            if (accept)   pcq_wr <= pcq_wr + 1'b1;
            if (rsp_fire) pcq_rd <= pcq_rd + 1'b1;
            if (redirect_valid) begin
                fetch_pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
                disc_cnt <= out_nxt;
                q_cnt    <= '0;
                q_rd     <= '0;
                q_wr     <= '0;
            end else begin
                if (accept) fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
                if (rsp_fire && disc_cnt != '0) disc_cnt <= disc_cnt - 1'b1;
                q_cnt <= q_cnt + CW'(push) - CW'(pop);
                if (push) q_wr <= q_wr + 1'b1;
                if (pop)  q_rd <= q_rd + 1'b1;
            end
        end
    end

    // Storage arrays; contents are don't-care until pointed at by a valid count.
    always_ff @(posedge clk) begin
        if (accept) pcq[pcq_wr] <= fetch_pc;
        if (push)   q_mem[q_wr] <= '{pc: pcq[pcq_rd], instr: imem_rsp_data};
    end

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, instruction width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, PC width.
REQ-003 SHALL have parameter DEPTH, default 4, queue entries; power of two, 2..16.
REQ-004 SHALL have parameter RESET_PC, default 0, first fetch address.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-008 SHALL have port imem_req_addr  output  ADDR_WIDTH  fetch address, word-aligned.
REQ-009 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-010 SHALL have port imem_rsp_valid  input  1  returned instruction valid; responses in request order.
REQ-011 SHALL have port imem_rsp_data  input  DATA_WIDTH  returned instruction word.
REQ-012 SHALL have port dec_valid  output  1  head entry valid toward decode/immediate-extension.
REQ-013 SHALL have port dec_instr  output  DATA_WIDTH  head instruction.
REQ-014 SHALL have port dec_pc  output  ADDR_WIDTH  PC of head instruction.
REQ-015 SHALL have port dec_ready  input  1  decode consumes head.
REQ-016 SHALL have port redirect_valid  input  1  jump/branch/call taken, flush.
REQ-017 SHALL have port redirect_pc  input  ADDR_WIDTH  new fetch target.
REQ-018 SHALL have port occupancy  output  clog2(DEPTH)+1  valid queue entries.

Function
REQ-019 SHALL issue a request (imem_req_valid=1) whenever occupancy + outstanding < DEPTH; imem_req_valid SHALL NOT depend combinationally on redirect_valid.
REQ-020 SHALL advance fetch PC by 4 on each accepted request (imem_req_valid & imem_req_ready); PC wraps modulo 2^ADDR_WIDTH.
REQ-021 SHALL track outstanding requests in a counter (+1 accept, -1 response, both same cycle = unchanged), max DEPTH.
REQ-022 SHALL push each non-discarded response into the queue tagged with its request PC (pc FIFO of DEPTH entries).
REQ-023 SHALL pop head on dec_valid & dec_ready; simultaneous push and pop SHALL leave occupancy unchanged, including when full.
REQ-024 dec_valid SHALL equal occupancy != 0 (non-bypass build); latency response->dec_valid = 1 cycle.
REQ-025 On redirect_valid: queue flushed (occupancy=0 next cycle), fetch PC := {redirect_pc[ADDR_WIDTH-1:2],2'b00}, discard counter := outstanding after this cycle's accept/response updates.
REQ-026 Responses arriving while discard counter > 0 SHALL be dropped and decrement it; a response in the redirect cycle itself SHALL be dropped.
REQ-027 A request accepted in the redirect cycle SHALL use the old PC and be counted for discard.
REQ-028 Pop in the redirect cycle SHALL be ignored; redirect has priority over push/pop.
REQ-029 imem_rsp_valid with outstanding=0 and discard=0 is illegal; SHALL be ignored.

Reset
REQ-030 On rst_n=0 asynchronously: fetch PC=RESET_PC, occupancy=0, outstanding=0, discard=0, imem_req_valid=0, dec_valid=0, dec_instr=0, dec_pc=0.
REQ-031 First request SHALL be asserted the first cycle after rst_n deasserts; reset mid-operation abandons all in-flight state; post-reset responses to pre-reset requests are the memory's responsibility.

Configuration
REQ-032 Macro FETCH_QUEUE_BYPASS_EN defined: response arriving with queue empty, discard=0, no redirect SHALL drive dec_valid/dec_instr/dec_pc combinationally that cycle; if dec_ready=1 it is consumed and not stored.
REQ-033 Macro undefined: no combinational path imem_rsp_* -> dec_*; REQ-024 latency holds.

Verification
REQ-034 Reset, imem_req_ready=1, 1-cycle memory, dec_ready=1 -> addresses 0x0,0x4,0x8...; dec_pc 0x0 first with dec_instr = returned word.
REQ-035 dec_ready=0 for 10 cycles, DEPTH=4 -> occupancy saturates at 4, imem_req_valid=0, no lost words; release -> 4 in-order pops.
REQ-036 Redirect to 0x103 with 2 outstanding -> next address 0x100; both stale responses dropped; first dec_pc=0x100.
REQ-037 Redirect coincident with response and accepted request -> response dropped, request discarded, occupancy 0 next cycle.
REQ-038 Fetch PC 0xFFFFFFFC accepted -> next address 0x00000000.
REQ-039 FETCH_QUEUE_BYPASS_EN defined, empty queue, response 0x12345678 with dec_ready=1 -> dec_valid=1 same cycle, occupancy stays 0.
